fme_tb_feeder: RTL and testbench

Controller and row register stage that sits directly upstream of the FME 8x8 transpose buffer. It accepts 8-pixel rows over a valid/ready stream and loads them into the buffer, then drains the transposed block column by column to the downstream interpolation stage. It drives the buffer's row inputs, `enable` and `direction`. The block owns the fill/drain sequencing, so the buffer itself stays purely shift-based.

---
 rtl/fme_tb_pkg.sv | 21 ++
 rtl/fme_tb_perf_cnt.sv | 17 +
 rtl/fme_tb_feeder.sv | 151 +++++++++++++++
 tb/tb_fme_tb_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_tb_pkg.sv
// rtl/fme_tb_pkg.sv - shared types and constants for the FME transpose-buffer feeder
package fme_tb_pkg;

  localparam int TB_ROWS  = 8;
  localparam int TB_CNT_W = 3;

  localparam logic TB_DIR_FILL  = 1'b0;
  localparam logic TB_DIR_DRAIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tb_feed_state_t;

  function automatic logic cnt_last(input logic [TB_CNT_W-1:0] c);
    return c == TB_CNT_W'(TB_ROWS - 1);
  endfunction

endpackage

// File: rtl/fme_tb_perf_cnt.sv
// rtl/fme_tb_perf_cnt.sv - 16-bit saturating event counter
module fme_tb_perf_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fme_tb_feeder.sv
// rtl/fme_tb_feeder.sv - row fill / column drain controller for the FME 8x8 transpose buffer
// Optional perf counters under TB_FEEDER_PERF_CNT_EN.
module fme_tb_feeder
  import fme_tb_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*DATAWIDTH-1:0] row_data,
  input  logic                   row_valid,
  output logic                   row_ready,
  output logic [DATAWIDTH-1:0]   tb_row_0,
  output logic [DATAWIDTH-1:0]   tb_row_1,
  output logic [DATAWIDTH-1:0]   tb_row_2,
  output logic [DATAWIDTH-1:0]   tb_row_3,
  output logic [DATAWIDTH-1:0]   tb_row_4,
  output logic [DATAWIDTH-1:0]   tb_row_5,
  output logic [DATAWIDTH-1:0]   tb_row_6,
  output logic [DATAWIDTH-1:0]   tb_row_7,
  output logic                   tb_enable,
  output logic                   tb_direction,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic [TB_CNT_W-1:0]    col_index,
  output logic                   blk_done
`ifdef TB_FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]            perf_blocks,
  output logic [15:0]            perf_stalls
`endif
);

  if (ROWS != TB_ROWS) begin : g_rows_check
    $error("fme_tb_feeder supports ROWS == 8 only");
  end

  tb_feed_state_t        state, state_d;
  logic [TB_CNT_W-1:0]   cnt, cnt_d;
  logic [DATAWIDTH-1:0]  row_q [TB_ROWS];
  logic                  fill_en_q;
  logic                  row_hs;

  // State register, row capture and the registered fill-enable pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_en_q <= 1'b0;
      for (int k = 0; k < TB_ROWS; k++) begin
        row_q[k] <= '0;
      end
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fill_en_q <= row_hs;
      if (row_hs) begin
        for (int k = 0; k < TB_ROWS; k++) begin
          row_q[k] <= row_data[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // The first DRAIN cycle carries the 8th row's fill pulse, so columns wait one cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (row_valid) begin
          state_d = FILL;
          cnt_d   = TB_CNT_W'(1);
        end
      end
      FILL: begin
        if (row_valid) begin
          if (cnt_last(cnt)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + TB_CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!fill_en_q && col_ready) begin
          if (cnt_last(cnt)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + TB_CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    row_ready    = 1'b0;
    col_valid    = 1'b0;
    blk_done     = 1'b0;
    tb_direction = TB_DIR_FILL;
    case (state)
      IDLE, FILL: row_ready = 1'b1;
      DRAIN: begin
        col_valid    = !fill_en_q;
        tb_direction = fill_en_q ? TB_DIR_FILL : TB_DIR_DRAIN;
      end
      DONE: blk_done = 1'b1;
      default: row_ready = 1'b0;
    endcase
    row_hs    = row_valid & row_ready;
    tb_enable = fill_en_q | (col_valid & col_ready);
  end

  assign col_index = cnt;
  assign tb_row_0  = row_q[0];
  assign tb_row_1  = row_q[1];
  assign tb_row_2  = row_q[2];
  assign tb_row_3  = row_q[3];
  assign tb_row_4  = row_q[4];
  assign tb_row_5  = row_q[5];
  assign tb_row_6  = row_q[6];
  assign tb_row_7  = row_q[7];

`ifdef TB_FEEDER_PERF_CNT_EN
  fme_tb_perf_cnt u_perf_blocks (
    .clock (clock),
    .reset (reset),
    .inc   (blk_done),
    .count (perf_blocks)
  );

  fme_tb_perf_cnt u_perf_stalls (
    .clock (clock),
    .reset (reset),
    .inc   (col_valid & ~col_ready),
    .count (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_fme_tb_feeder.sv
// tb/tb_fme_tb_feeder.sv - directed self-checking bench for fme_tb_feeder
module tb_fme_tb_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] row_data = '0;
  logic        row_valid = 1'b0;
  logic        row_ready;
  logic [7:0]  tb_row_0, tb_row_1, tb_row_2, tb_row_3;
  logic [7:0]  tb_row_4, tb_row_5, tb_row_6, tb_row_7;
  logic        tb_enable, tb_direction, col_valid;
  logic        col_ready = 1'b0;
  logic [2:0]  col_index;
  logic        blk_done;
`ifdef TB_FEEDER_PERF_CNT_EN
  logic [15:0] perf_blocks, perf_stalls;
`endif

  int checks = 0;
  int failures = 0;

  wire [63:0] rows_flat = {tb_row_7, tb_row_6, tb_row_5, tb_row_4,
                           tb_row_3, tb_row_2, tb_row_1, tb_row_0};

  fme_tb_feeder #(.DATAWIDTH(8), .ROWS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .row_data     (row_data),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .tb_row_0     (tb_row_0),
    .tb_row_1     (tb_row_1),
    .tb_row_2     (tb_row_2),
    .tb_row_3     (tb_row_3),
    .tb_row_4     (tb_row_4),
    .tb_row_5     (tb_row_5),
    .tb_row_6     (tb_row_6),
    .tb_row_7     (tb_row_7),
    .tb_enable    (tb_enable),
    .tb_direction (tb_direction),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .col_index    (col_index),
    .blk_done     (blk_done)
`ifdef TB_FEEDER_PERF_CNT_EN
    ,
    .perf_blocks  (perf_blocks),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] mk_row(input int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(8*r + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_block(input int base);
    for (int r = 0; r < 8; r++) begin
      row_valid = 1'b1;
      row_data  = mk_row(base + r);
      tick();
    end
    row_valid = 1'b0;
  endtask

  task automatic drain_to_done();
    logic seen;
    seen = 1'b0;
    col_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (blk_done) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL drain_done got=%0b exp=1", seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (rows_flat !== 64'h0) begin failures++; $display("FAIL reset_rows got=%h exp=0", rows_flat); end
    checks++; if (tb_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", tb_enable); end
    checks++; if (row_ready !== 1'b1) begin failures++; $display("FAIL reset_row_ready got=%b exp=1", row_ready); end
    checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL reset_col_valid got=%b exp=0", col_valid); end
    checks++; if (blk_done !== 1'b0) begin failures++; $display("FAIL reset_blk_done got=%b exp=0", blk_done); end
    tick();
  endtask

  task automatic test_full_rate();
    int fills, ncols, done_cyc;
    fills = 0; ncols = 0; done_cyc = -1;
    col_ready = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 8) begin
        row_valid = 1'b1;
        row_data  = mk_row(c - 1);
      end else begin
        row_valid = 1'b0;
      end
      @(negedge clock);
      checks++;
      if (row_ready !== (c <= 8)) begin
        failures++; $display("FAIL full_row_ready cyc=%0d got=%b exp=%b", c, row_ready, (c <= 8));
      end
      checks++;
      if (col_valid !== (c >= 10 && c <= 17)) begin
        failures++; $display("FAIL full_col_valid cyc=%0d got=%b exp=%b", c, col_valid, (c >= 10 && c <= 17));
      end
      if (tb_enable && tb_direction == 1'b0) begin
        checks++;
        if (rows_flat !== mk_row(c - 2)) begin
          failures++; $display("FAIL full_fill_row cyc=%0d got=%h exp=%h", c, rows_flat, mk_row(c - 2));
        end
        fills++;
      end
      if (col_valid) begin
        checks++;
        if (col_index !== 3'(ncols) || tb_enable !== 1'b1 || tb_direction !== 1'b1) begin
          failures++; $display("FAIL full_column cyc=%0d got=%0d/%b/%b exp=%0d/1/1", c, col_index, tb_enable, tb_direction, ncols);
        end
        ncols++;
      end
      if (blk_done && done_cyc < 0) done_cyc = c;
      tick();
    end
    checks++; if (fills !== 8) begin failures++; $display("FAIL full_fill_count got=%0d exp=8", fills); end
    checks++; if (ncols !== 8) begin failures++; $display("FAIL full_col_count got=%0d exp=8", ncols); end
    checks++; if (done_cyc !== 18) begin failures++; $display("FAIL full_done_cycle got=%0d exp=18", done_cyc); end
  endtask

  task automatic test_input_gaps();
    logic [63:0] exp_row;
    for (int c = 1; c <= 5; c++) begin
      row_valid = (c == 1 || c == 3);
      row_data  = row_valid ? mk_row(19 + (c + 1) / 2) : mk_row(99);
      @(negedge clock);
      checks++;
      if (tb_enable !== (c == 2 || c == 4)) begin
        failures++; $display("FAIL gap_enable cyc=%0d got=%b exp=%b", c, tb_enable, (c == 2 || c == 4));
      end
      if (c >= 2) begin
        exp_row = (c < 4) ? mk_row(20) : mk_row(21);
        checks++;
        if (rows_flat !== exp_row) begin
          failures++; $display("FAIL gap_rows cyc=%0d got=%h exp=%h", c, rows_flat, exp_row);
        end
      end
      tick();
    end
    row_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_drain_stall();
    col_ready = 1'b1;
    fill_block(40);
    @(negedge clock);
    checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL stall_turn got=%b exp=0", col_valid); end
    tick();
    for (int i = 0; i < 3; i++) tick();
    col_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      checks++;
      if (col_valid !== 1'b1 || col_index !== 3'd3 || tb_enable !== 1'b0) begin
        failures++; $display("FAIL stall_hold s=%0d got=%b/%0d/%b exp=1/3/0", s, col_valid, col_index, tb_enable);
      end
      tick();
    end
    col_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (col_index !== 3'(i)) begin failures++; $display("FAIL stall_resume got=%0d exp=%0d", col_index, i); end
      tick();
    end
    @(negedge clock);
    checks++;
    if (blk_done !== 1'b1 || col_valid !== 1'b0 || row_ready !== 1'b0) begin
      failures++; $display("FAIL stall_done got=%b/%b/%b exp=1/0/0", blk_done, col_valid, row_ready);
    end
    tick();
`ifdef TB_FEEDER_PERF_CNT_EN
    checks++; if (perf_stalls !== 16'd5) begin failures++; $display("FAIL perf_stalls got=%0d exp=5", perf_stalls); end
    checks++; if (perf_blocks !== 16'd1) begin failures++; $display("FAIL perf_blocks got=%0d exp=1", perf_blocks); end
`endif
  endtask

  task automatic test_reset_mid_drain();
    col_ready = 1'b1;
    fill_block(60);
    tick();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clock);
    checks++;
    if (col_valid !== 1'b1 || col_index !== 3'd4) begin
      failures++; $display("FAIL mid_pre got=%b/%0d exp=1/4", col_valid, col_index);
    end
    reset = 1'b1;
    col_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (col_valid !== 1'b0 || row_ready !== 1'b1 || col_index !== 3'd0 || rows_flat !== 64'h0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%0d/%h exp=0/1/0/0", col_valid, row_ready, col_index, rows_flat);
    end
    tick();
    col_ready = 1'b1;
    fill_block(70);
    tick();
    @(negedge clock);
    checks++;
    if (col_valid !== 1'b1 || col_index !== 3'd0 || tb_direction !== 1'b1) begin
      failures++; $display("FAIL mid_restart got=%b/%0d/%b exp=1/0/1", col_valid, col_index, tb_direction);
    end
    tick();
    drain_to_done();
  endtask

`ifdef TB_FEEDER_PERF_CNT_EN
  task automatic test_saturation();
    force dut.u_perf_blocks.count = 16'hFFFE;
    tick();
    release dut.u_perf_blocks.count;
    for (int b = 0; b < 3; b++) begin
      fill_block(b);
      drain_to_done();
      checks++;
      if (perf_blocks !== 16'hFFFF) begin
        failures++; $display("FAIL perf_saturate blk=%0d got=%h exp=ffff", b, perf_blocks);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_input_gaps();
    test_drain_stall();
    test_reset_mid_drain();
`ifdef TB_FEEDER_PERF_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
